path_replayer: RTL and testbench
================================

// Module: path_replayer
// PURPOSE
//  Path store and reader for the maze solver. The solver writes its current path as a
//  LIFO of 2-bit moves: push on advance, pop on backtrack. On run, this block reads the
//  stored path back oldest-first and emits one move per handshake, with running
//  coordinates, toward the cell driver / display. It is the read side of the solver path.
// PARAMETERS
//  DEPTH    256  maximum stored moves (power of 2)
//  AW       8    pointer width, log2(DEPTH)
//  CW       4    coordinate width (maze is 2^CW x 2^CW)
//  START_X  0    x coordinate of maze entry
//  START_Y  0    y coordinate of maze entry
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-high reset
//  push      in   1      solver advanced; store push_dir on top
//  pop       in   1      solver backtracked; discard top
//  push_dir  in   2      0=up(y-1) 1=right(x+1) 2=down(y+1) 3=left(x-1)
//  clear     in   1      sync: empty the store (honoured in IDLE only)
//  run       in   1      start replay (sampled in IDLE)
//  mv_valid  out  1      move presented
//  mv_ready  in   1      consumer accepts move
//  mv_dir    out  2      direction of presented move
//  mv_x      out  CW     x after presented move
//  mv_y      out  CW     y after presented move
//  count     out  AW+1   stored moves
//  empty     out  1      count==0
//  full      out  1      count==DEPTH
//  busy      out  1      state != IDLE
//  done      out  1      1-cycle pulse, replay finished
//  err       out  1      sticky: illegal write; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, count=0, rd_ptr=0, x/y=START, mv_valid=0, done=0, err=0.
//   Memory contents are not cleared. Reset mid-replay aborts with no done pulse.
//  IDLE, write side (count updates on the clock edge; no read-back latency):
//   push only: mem[count]=push_dir, count+1. If full: ignored, err=1.
//   pop only:  count-1. If empty: ignored, err=1.
//   push&pop:  top is replaced, mem[count-1]=push_dir, count unchanged.
//    If empty, acts as a plain push.
//   clear:     count=0. Has priority over push/pop in the same cycle.
//   run:       has priority over write inputs in the same cycle (they are dropped,
//              and err is not set). rd_ptr=0, x/y=START.
//              If count>0, go to REPLAY. If count==0, go to FINISH.
//  REPLAY:
//   mv_valid=1. mv_dir=mem[rd_ptr]. mv_x/mv_y = current x/y stepped by mv_dir,
//    computed combinationally and wrapping mod 2^CW.
//   The first move is valid the cycle after run is sampled.
//   Outputs hold stable while mv_valid && !mv_ready.
//   Handshake (mv_valid && mv_ready): x/y take the presented values, rd_ptr+1.
//    On the last entry (rd_ptr==count-1), go to FINISH. Sustained throughput is 1 move/cycle.
//   push/pop/clear are ignored here and set err=1. run is ignored.
//  FINISH: done=1 for one cycle, mv_valid=0, go to IDLE. The store keeps its contents,
//   so run can be issued again to repeat the replay.
//  count, empty and full are registered. err never self-clears.
// TESTING
//  1. push 1,1,2,2,3 (START 0,0); run, mv_ready=1 -> moves (1,0)(2,0)(2,1)(2,2)(1,2),
//     one per cycle from cycle run+1, done on the cycle after the 5th, err=0.
//  2. push 1,2; pop; push 2 -> count=2. Replay gives (1,0) then (1,1).
//     push&pop together on top -> count unchanged, top replaced.
//  3. Replay with mv_ready toggling 1,0,0,1... -> outputs held while stalled,
//     no move lost or duplicated, done only after the last handshake.
//  4. DEPTH pushes then 1 more -> full=1, count=DEPTH, err=1.
//     clear -> count=0, empty=1, err stays 1. pop on empty -> err=1, count stays 0.
//  5. run with count=0 -> mv_valid never 1, done pulses at run+1.
//     push during REPLAY -> ignored, err=1.
//  6. Assert rst mid-replay -> all outputs at reset values immediately, no done pulse.
//     Left move from x=0 wraps to x=2^CW-1.

Source files
------------

// File: rtl/path_replayer_if.sv
// Move handshake from the path replayer to the cell driver / display.
// valid/ready: a move transfers on a cycle where mv_valid && mv_ready; while mv_valid is high and mv_ready low, mv_dir/mv_x/mv_y hold stable.
interface path_replayer_if #(
  parameter int CW = 4
);
  logic          mv_valid;
  logic          mv_ready;
  logic [1:0]    mv_dir;
  logic [CW-1:0] mv_x;
  logic [CW-1:0] mv_y;

  modport master (output mv_valid, output mv_dir, output mv_x, output mv_y, input mv_ready);
  modport slave  (input mv_valid, input mv_dir, input mv_x, input mv_y, output mv_ready);
endinterface

// File: rtl/path_replayer.sv
// LIFO store of solver moves; on run, replays them oldest-first over a valid/ready
// handshake with running maze coordinates.
module path_replayer #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int CW      = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [1:0]       i_push_dir,
  input  logic             i_clear,
  input  logic             i_run,
  path_replayer_if.master  mv,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [1:0]       o_state
);

  localparam logic [CW-1:0] SX      = CW'(START_X);
  localparam logic [CW-1:0] SY      = CW'(START_Y);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPLAY = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_err;
  logic [1:0]    r_mem [DEPTH];

  state_t        w_state_nxt;
  logic [AW:0]   w_count_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic          w_err_nxt;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [1:0]    w_dir;
  logic [CW-1:0] w_step_x;
  logic [CW-1:0] w_step_y;
  logic          w_last;
  logic          w_valid;

  // Presented move: current position stepped by the stored direction, wrapping mod 2^CW.
  always_comb begin
    w_dir    = r_mem[r_rd_ptr];
    w_step_x = r_x;
    w_step_y = r_y;
    case (w_dir)
      2'd0:    w_step_y = r_y - CW'(1);
      2'd1:    w_step_x = r_x + CW'(1);
      2'd2:    w_step_y = r_y + CW'(1);
      default: w_step_x = r_x - CW'(1);
    endcase
  end

  assign w_valid     = (r_state == S_REPLAY);
  assign w_last      = ({1'b0, r_rd_ptr} == (r_count - (AW+1)'(1)));
  assign mv.mv_valid = w_valid;
  assign mv.mv_dir   = w_valid ? w_dir : 2'd0;
  assign mv.mv_x     = w_valid ? w_step_x : r_x;
  assign mv.mv_y     = w_valid ? w_step_y : r_y;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_err_nxt    = r_err;
    w_we         = 1'b0;
    w_waddr      = r_count[AW-1:0];
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_rd_ptr_nxt = '0;
          w_x_nxt      = SX;
          w_y_nxt      = SY;
          w_state_nxt  = (r_count != '0) ? S_REPLAY : S_FINISH;
        end else if (i_clear) begin
          w_count_nxt = '0;
        end else if (i_push && i_pop) begin
          w_we = 1'b1;
          if (r_empty) begin
            w_waddr     = '0;
            w_count_nxt = (AW+1)'(1);
          end else begin
            // Replacing the top; when full the low bits of count wrap, so -1 still lands on DEPTH-1.
            w_waddr = r_count[AW-1:0] - AW'(1);
          end
        end else if (i_push) begin
          if (r_full) begin
            w_err_nxt = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_count_nxt = r_count + (AW+1)'(1);
          end
        end else if (i_pop) begin
          if (r_empty) w_err_nxt = 1'b1;
          else         w_count_nxt = r_count - (AW+1)'(1);
        end
      end
      S_REPLAY: begin
        if (i_push || i_pop || i_clear) w_err_nxt = 1'b1;
        if (mv.mv_ready) begin
          w_x_nxt      = w_step_x;
          w_y_nxt      = w_step_y;
          w_rd_ptr_nxt = r_rd_ptr + AW'(1);
          if (w_last) w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        // Writes cannot be honoured outside IDLE, so they are flagged here too.
        if (i_push || i_pop || i_clear) w_err_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_rd_ptr <= '0;
      r_x      <= SX;
      r_y      <= SY;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == DEPTH_C);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= i_push_dir;
  end

  assign o_count = r_count;
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_FINISH);
  assign o_err   = r_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_path_replayer.sv
// Directed/randomized bench for path_replayer against a queue-based path model.
module tb_path_replayer;
  localparam int DEPTH   = 256;
  localparam int AW      = 8;
  localparam int CW      = 4;
  localparam int START_X = 0;
  localparam int START_Y = 0;
  localparam int MASK    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_push = 1'b0;
  logic          i_pop = 1'b0;
  logic [1:0]    i_push_dir = 2'd0;
  logic          i_clear = 1'b0;
  logic          i_run = 1'b0;
  logic [AW:0]   o_count;
  logic          o_empty, o_full, o_busy, o_done, o_err;
  logic [1:0]    o_state;

  path_replayer_if #(.CW(CW)) mv_if ();

  path_replayer #(
    .DEPTH(DEPTH), .AW(AW), .CW(CW), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .clk(clk), .rst(rst), .i_push(i_push), .i_pop(i_pop), .i_push_dir(i_push_dir),
    .i_clear(i_clear), .i_run(i_run), .mv(mv_if), .o_count(o_count), .o_empty(o_empty),
    .o_full(o_full), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int q[$];        // model of the stored path, oldest first
  bit m_err = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_store();
    check("count", 32'(o_count), 32'(q.size()));
    check("empty", 32'(o_empty), 32'(q.size() == 0));
    check("full",  32'(o_full),  32'(q.size() == DEPTH));
    check("err",   32'(o_err),   32'(m_err));
  endtask

  task automatic do_write(input bit push, input bit pop, input bit clr, input logic [1:0] dir);
    i_push = push; i_pop = pop; i_clear = clr; i_push_dir = dir;
    tick();
    i_push = 1'b0; i_pop = 1'b0; i_clear = 1'b0;
    if (clr) q.delete();
    else if (push && pop) begin
      if (q.size() == 0) q.push_back(int'(dir));
      else q[q.size()-1] = int'(dir);
    end else if (push) begin
      if (q.size() == DEPTH) m_err = 1'b1;
      else q.push_back(int'(dir));
    end else if (pop) begin
      if (q.size() == 0) m_err = 1'b1;
      else void'(q.pop_back());
    end
    check_store();
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0,...; 2: random ready
  task automatic do_replay(input int mode, input bit inj_push, input bit run_with_push);
    int xs[$];
    int ys[$];
    int x, y, idx, cyc;
    bit rdy;
    x = START_X; y = START_Y;
    foreach (q[i]) begin
      case (q[i])
        0: y = (y - 1) & MASK;
        1: x = (x + 1) & MASK;
        2: y = (y + 1) & MASK;
        default: x = (x - 1) & MASK;
      endcase
      xs.push_back(x);
      ys.push_back(y);
    end
    i_run = 1'b1;
    if (run_with_push) begin
      i_push = 1'b1;
      i_push_dir = 2'($urandom_range(0, 3));
    end
    tick();
    i_run = 1'b0; i_push = 1'b0;
    if (q.size() == 0) begin
      check("empty_run_valid", 32'(mv_if.mv_valid), 32'd0);
      check("empty_run_done",  32'(o_done), 32'd1);
      tick();
      check("empty_run_done_end", 32'(o_done), 32'd0);
      check("empty_run_busy_end", 32'(o_busy), 32'd0);
      return;
    end
    idx = 0; cyc = 0;
    while (idx < q.size() && cyc < 4 * q.size() + 20) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (inj_push && cyc == 0) begin
        i_push = 1'b1;
        m_err = 1'b1;
      end
      mv_if.mv_ready = rdy;
      check("mv_valid", 32'(mv_if.mv_valid), 32'd1);
      check("mv_dir",   32'(mv_if.mv_dir),   32'(q[idx]));
      check("mv_x",     32'(mv_if.mv_x),     32'(xs[idx]));
      check("mv_y",     32'(mv_if.mv_y),     32'(ys[idx]));
      check("done_early", 32'(o_done), 32'd0);
      tick();
      i_push = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    mv_if.mv_ready = 1'b0;
    check("replay_moves", 32'(idx), 32'(q.size()));
    if (mode == 0) check("replay_cycles", 32'(cyc), 32'(q.size()));
    check("done_pulse", 32'(o_done), 32'd1);
    check("valid_after", 32'(mv_if.mv_valid), 32'd0);
    check_store();
    tick();
    check("done_end", 32'(o_done), 32'd0);
    check("busy_end", 32'(o_busy), 32'd0);
  endtask

  initial begin
    mv_if.mv_ready = 1'b0;
    // reset
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(mv_if.mv_valid), 32'd0);
    check("rst_done",  32'(o_done), 32'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    check_store();

    // fixed path 1,1,2,2,3
    do_write(1, 0, 0, 2'd1); do_write(1, 0, 0, 2'd1); do_write(1, 0, 0, 2'd2);
    do_write(1, 0, 0, 2'd2); do_write(1, 0, 0, 2'd3);
    do_replay(0, 0, 0);
    do_replay(2, 0, 0);

    // push/pop mix and stalled replay
    do_write(0, 0, 1, 2'd0);
    do_write(1, 0, 0, 2'd1); do_write(1, 0, 0, 2'd2); do_write(0, 1, 0, 2'd0);
    do_write(1, 0, 0, 2'd2);
    do_replay(1, 0, 0);
    do_write(1, 1, 0, 2'd3);
    do_write(1, 1, 1, 2'd0);   // clear beats push&pop
    do_write(1, 1, 0, 2'd1);   // push&pop on empty acts as push
    do_replay(0, 0, 1);        // run drops a simultaneous push, no err

    // randomized write traffic and replays
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 24; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        do_write(sel < 6 || sel == 9, sel >= 6, 1'b0, 2'($urandom_range(0, 3)));
      end
      do_replay(2, 0, 0);
    end

    // empty run, then push during replay
    do_write(0, 0, 1, 2'd0);
    do_replay(0, 0, 0);
    do_write(1, 0, 0, 2'd2); do_write(1, 0, 0, 2'd1);
    do_replay(2, 1, 0);

    // fill to DEPTH, overflow, full replay, clear, underflow
    do_write(0, 0, 1, 2'd0);
    for (int k = 0; k < DEPTH; k++) do_write(1, 0, 0, 2'($urandom_range(0, 3)));
    do_write(1, 0, 0, 2'd1);
    do_write(1, 1, 0, 2'd3);   // top replace while full
    do_replay(0, 0, 0);
    do_write(0, 0, 1, 2'd0);
    do_write(0, 1, 0, 2'd0);

    // reset mid-replay
    do_write(1, 0, 0, 2'd1); do_write(1, 0, 0, 2'd1); do_write(1, 0, 0, 2'd2);
    i_run = 1'b1; tick(); i_run = 1'b0;
    mv_if.mv_ready = 1'b1; tick(); mv_if.mv_ready = 1'b0;
    rst = 1'b1;
    #1;
    q.delete(); m_err = 1'b0;
    check("midrst_valid", 32'(mv_if.mv_valid), 32'd0);
    check("midrst_done",  32'(o_done), 32'd0);
    check("midrst_busy",  32'(o_busy), 32'd0);
    check_store();
    tick();
    check("midrst_done_hold", 32'(o_done), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_done", 32'(o_done), 32'd0);

    // coordinate wrap both axes
    do_write(1, 0, 0, 2'd3); do_write(1, 0, 0, 2'd0); do_write(1, 0, 0, 2'd0);
    do_replay(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    n_miss++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end
endmodule
